// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - FunSel codes and arbiter state encodings for the register bank
package reg_bank_pkg;

    localparam logic [2:0] FS_DEC   = 3'b000;
    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LOAD  = 3'b010;
    localparam logic [2:0] FS_CLR   = 3'b011;
    localparam logic [2:0] FS_LDL_Z = 3'b100;
    localparam logic [2:0] FS_LDL   = 3'b101;
    localparam logic [2:0] FS_LDH   = 3'b110;
    localparam logic [2:0] FS_SEXT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick2.sv
// rtl/reg_bank_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic pick_a,
    output logic pick_b
);

    // On a tie the requester that was not granted last wins.
    assign pick_a = req_a & (~req_b | last_b);
    assign pick_b = req_b & (~req_a | ~last_b);

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-requester arbiter driving a shared register bank load interface
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter  int NUM_REGS = 4,
    parameter  int DATA_W   = 16,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                ReqA,
    input  logic                ReqB,
    input  logic                ClrA,
    input  logic                ClrB,
    input  logic [SEL_W-1:0]    AddrA,
    input  logic [SEL_W-1:0]    AddrB,
    input  logic [2:0]          FunSelA,
    input  logic [2:0]          FunSelB,
    input  logic [DATA_W-1:0]   DataA,
    input  logic [DATA_W-1:0]   DataB,
    output logic                GntA,
    output logic                GntB,
    output logic                ErrA,
    output logic                ErrB,
    output logic [NUM_REGS-1:0] RegE,
    output logic [2:0]          RegFunSel,
    output logic [DATA_W-1:0]   RegI,
    output logic                Busy
);

    localparam logic [SEL_W:0]      NUM_REGS_W = NUM_REGS[SEL_W:0];
    localparam logic [SEL_W-1:0]    LAST_IDX   = SEL_W'(NUM_REGS - 1);
    localparam logic [NUM_REGS-1:0] ONE        = {{(NUM_REGS-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic                last_b_q, last_b_d;
    logic                win_b_q, win_b_d;
    logic [NUM_REGS-1:0] reg_e_q, reg_e_d;
    logic [2:0]          reg_fs_q, reg_fs_d;
    logic [DATA_W-1:0]   reg_i_q, reg_i_d;
    logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic                err_a_q, err_a_d, err_b_q, err_b_d;
    logic                busy_q, busy_d;

    logic                pick_a, pick_b;
    logic [SEL_W-1:0]    win_addr;
    logic                win_in_range;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot = ({1'b0, i} < NUM_REGS_W) ? (ONE << i) : '0;
    endfunction

    rr_pick2 u_pick (
        .req_a  (ReqA),
        .req_b  (ReqB),
        .last_b (last_b_q),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    assign win_addr     = win_b_d ? AddrB : AddrA;
    assign win_in_range = ({1'b0, win_addr} < NUM_REGS_W);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_b_q <= 1'b1;
            win_b_q  <= 1'b0;
            reg_e_q  <= '0;
            reg_fs_q <= '0;
            reg_i_q  <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            err_a_q  <= 1'b0;
            err_b_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_b_q <= last_b_d;
            win_b_q  <= win_b_d;
            reg_e_q  <= reg_e_d;
            reg_fs_q <= reg_fs_d;
            reg_i_q  <= reg_i_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            err_a_q  <= err_a_d;
            err_b_q  <= err_b_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_b_d = last_b_q;
        win_b_d  = win_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_a || pick_b) begin
                    win_b_d  = pick_b;
                    last_b_d = pick_b;
                    idx_d    = '0;
                    state_d  = (pick_b ? ClrB : ClrA) ? ST_CLEAR : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
                else                   idx_d   = idx_q + SEL_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they appear registered in the cycle they describe.
    always_comb begin
        reg_e_d  = '0;
        reg_fs_d = '0;
        reg_i_d  = '0;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        err_a_d  = 1'b0;
        err_b_d  = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        unique case (state_d)
            ST_ISSUE: begin
                reg_e_d  = onehot(win_addr);
                reg_fs_d = win_b_d ? FunSelB : FunSelA;
                reg_i_d  = win_b_d ? DataB : DataA;
                gnt_a_d  = ~win_b_d;
                gnt_b_d  = win_b_d;
                err_a_d  = ~win_b_d & ~win_in_range;
                err_b_d  = win_b_d & ~win_in_range;
            end
            ST_CLEAR: begin
                reg_e_d  = onehot(idx_d);
                reg_fs_d = FS_CLR;
                gnt_a_d  = (idx_d == LAST_IDX) & ~win_b_d;
                gnt_b_d  = (idx_d == LAST_IDX) & win_b_d;
            end
            default: ;
        endcase
    end

    assign GntA      = gnt_a_q;
    assign GntB      = gnt_b_q;
    assign ErrA      = err_a_q;
    assign ErrB      = err_b_q;
    assign RegE      = reg_e_q;
    assign RegFunSel = reg_fs_q;
    assign RegI      = reg_i_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;
    import reg_bank_pkg::*;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;
    logic ResetN = 1'b0;

    logic        ReqA = 0, ReqB = 0, ClrA = 0, ClrB = 0;
    logic [1:0]  AddrA = 0, AddrB = 0;
    logic [2:0]  FunSelA = 0, FunSelB = 0;
    logic [15:0] DataA = 0, DataB = 0;
    logic        GntA, GntB, ErrA, ErrB, Busy;
    logic [3:0]  RegE;
    logic [2:0]  RegFunSel;
    logic [15:0] RegI;

    logic        c_ReqA = 0, c_ReqB = 0, c_ClrA = 0, c_ClrB = 0;
    logic [1:0]  c_AddrA = 0, c_AddrB = 0;
    logic [2:0]  c_FunSelA = 0, c_FunSelB = 0;
    logic [15:0] c_DataA = 0, c_DataB = 0;
    logic        c_GntA, c_GntB, c_ErrA, c_ErrB, c_Busy;
    logic [2:0]  c_RegE;
    logic [2:0]  c_RegFunSel;
    logic [15:0] c_RegI;

    reg_bank_arbiter #(.NUM_REGS(4), .DATA_W(16)) dut (
        .Clock(Clock), .ResetN(ResetN), .ReqA(ReqA), .ReqB(ReqB), .ClrA(ClrA), .ClrB(ClrB),
        .AddrA(AddrA), .AddrB(AddrB), .FunSelA(FunSelA), .FunSelB(FunSelB), .DataA(DataA), .DataB(DataB),
        .GntA(GntA), .GntB(GntB), .ErrA(ErrA), .ErrB(ErrB), .RegE(RegE), .RegFunSel(RegFunSel),
        .RegI(RegI), .Busy(Busy)
    );

    reg_bank_arbiter #(.NUM_REGS(3), .DATA_W(16)) dut3 (
        .Clock(Clock), .ResetN(ResetN), .ReqA(c_ReqA), .ReqB(c_ReqB), .ClrA(c_ClrA), .ClrB(c_ClrB),
        .AddrA(c_AddrA), .AddrB(c_AddrB), .FunSelA(c_FunSelA), .FunSelB(c_FunSelB),
        .DataA(c_DataA), .DataB(c_DataB), .GntA(c_GntA), .GntB(c_GntB), .ErrA(c_ErrA), .ErrB(c_ErrB),
        .RegE(c_RegE), .RegFunSel(c_RegFunSel), .RegI(c_RegI), .Busy(c_Busy)
    );

    typedef struct {
        logic        gnt_b;
        logic [3:0]  rege;
        logic [2:0]  fs;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        req_a, req_b, clr_a, clr_b;
        logic [1:0]  addr_a, addr_b;
        logic [2:0]  fs_a, fs_b;
        logic [15:0] data_a, data_b;
        logic        first_b;
    } vec_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] oh4(input logic [1:0] a);
        logic [3:0] one;
        one = 4'b0001;
        return one << a;
    endfunction

    task automatic push_op(input logic b, input logic clr, input logic [1:0] addr,
                           input logic [2:0] fs, input logic [15:0] d);
        exp_t e;
        e.gnt_b = b;
        e.rege  = clr ? 4'b1000 : oh4(addr);
        e.fs    = clr ? FS_CLR : fs;
        e.data  = clr ? 16'h0 : d;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every grant pops the next expected operation.
    always @(negedge Clock) begin
        if (GntA || GntB) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_gnt actual=%b%b required=none", GntA, GntB);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_gnt", {GntA, GntB}, e.gnt_b ? 2'b01 : 2'b10);
                chk("sb_rege", RegE, e.rege);
                chk("sb_funsel", RegFunSel, e.fs);
                chk("sb_regi", RegI, e.data);
                chk("sb_err", {ErrA, ErrB}, 2'b00);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic run_entry(input int n, input vec_t v);
        logic pend_a, pend_b;
        int   cyc;
        if (v.req_a && v.req_b) begin
            if (v.first_b) begin
                push_op(1'b1, v.clr_b, v.addr_b, v.fs_b, v.data_b);
                push_op(1'b0, v.clr_a, v.addr_a, v.fs_a, v.data_a);
            end else begin
                push_op(1'b0, v.clr_a, v.addr_a, v.fs_a, v.data_a);
                push_op(1'b1, v.clr_b, v.addr_b, v.fs_b, v.data_b);
            end
        end else if (v.req_a) push_op(1'b0, v.clr_a, v.addr_a, v.fs_a, v.data_a);
        else if (v.req_b)     push_op(1'b1, v.clr_b, v.addr_b, v.fs_b, v.data_b);
        ReqA = v.req_a; ClrA = v.clr_a; AddrA = v.addr_a; FunSelA = v.fs_a; DataA = v.data_a;
        ReqB = v.req_b; ClrB = v.clr_b; AddrB = v.addr_b; FunSelB = v.fs_b; DataB = v.data_b;
        pend_a = v.req_a;
        pend_b = v.req_b;
        cyc = 0;
        while ((pend_a || pend_b) && cyc < 40) begin
            @(negedge Clock);
            cyc++;
            if (GntA) begin pend_a = 0; ReqA = 0; ClrA = 0; end
            if (GntB) begin pend_b = 0; ReqB = 0; ClrB = 0; end
        end
        if (pend_a || pend_b) begin
            checks++;
            failures++;
            $display("FAIL entry%0d_timeout actual=pending%b%b required=granted", n, pend_a, pend_b);
        end
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        ReqA = 0; ReqB = 0; ClrA = 0; ClrB = 0;
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);
    endtask

    vec_t tbl[6];
    int   g[4];
    int   ng;

    initial begin
        tbl[0] = '{1, 0, 0, 0, 2'd1, 2'd0, FS_INC,  FS_DEC,   16'h1234, 16'h0000, 0};
        tbl[1] = '{0, 1, 0, 0, 2'd0, 2'd3, FS_DEC,  FS_SEXT,  16'h0000, 16'h8001, 1};
        tbl[2] = '{1, 1, 0, 0, 2'd0, 2'd2, FS_LOAD, FS_LDL_Z, 16'hAAAA, 16'h5555, 0};
        tbl[3] = '{1, 0, 0, 0, 2'd2, 2'd0, FS_DEC,  FS_DEC,   16'h0000, 16'h0000, 0};
        tbl[4] = '{1, 1, 0, 0, 2'd3, 2'd0, FS_LDL,  FS_LDH,   16'hF00D, 16'hCAFE, 1};
        tbl[5] = '{0, 1, 0, 1, 2'd0, 2'd2, FS_DEC,  FS_LOAD,  16'h0000, 16'hFFFF, 1};

        do_reset();
        chk("reset_outputs", {GntA, GntB, ErrA, ErrB, Busy, RegE, RegFunSel, RegI}, '0);

        // Single A load: one-cycle latency, then back to IDLE.
        ReqA = 1; AddrA = 2'd2; FunSelA = FS_LOAD; DataA = 16'hBEEF;
        push_op(1'b0, 1'b0, 2'd2, FS_LOAD, 16'hBEEF);
        @(negedge Clock);
        chk("t1_gnta", GntA, 1'b1);
        chk("t1_rege", RegE, 4'b0100);
        chk("t1_regi", RegI, 16'hBEEF);
        chk("t1_busy", Busy, 1'b1);
        ReqA = 0;
        @(negedge Clock);
        chk("t1_idle", {GntA, Busy, RegE}, '0);

        for (int i = 0; i < 6; i++) run_entry(i, tbl[i]);
        @(negedge Clock);
        chk("tbl_sb_drained", sb_q.size(), 0);

        // Both held for four rounds: A,B,A,B on every other cycle.
        do_reset();
        ReqA = 1; AddrA = 2'd0; FunSelA = FS_LOAD; DataA = 16'h1111;
        ReqB = 1; AddrB = 2'd1; FunSelB = FS_INC;  DataB = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            push_op(1'b0, 1'b0, 2'd0, FS_LOAD, 16'h1111);
            push_op(1'b1, 1'b0, 2'd1, FS_INC, 16'h2222);
        end
        ng = 0;
        for (int c = 1; c <= 20 && ng < 4; c++) begin
            @(negedge Clock);
            if (GntA || GntB) begin
                g[ng] = c;
                ng++;
            end
            if (ng == 4) begin ReqA = 0; ReqB = 0; end
        end
        chk("t2_num_grants", ng, 4);
        for (int i = 0; i < 4; i++) chk("t2_grant_cycle", (i < ng) ? g[i] : -1, 1 + 2 * i);

        // B clear walk, with A arriving mid-walk.
        @(negedge Clock);
        ReqB = 1; ClrB = 1; AddrB = 2'd2; FunSelB = FS_LOAD; DataB = 16'hFFFF;
        push_op(1'b1, 1'b1, 2'd0, FS_CLR, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            chk("t3_rege", RegE, oh4(2'(i)));
            chk("t3_funsel_regi", {RegFunSel, RegI}, {FS_CLR, 16'h0});
            chk("t3_gntb", {GntA, GntB}, (i == 3) ? 2'b01 : 2'b00);
            chk("t3_busy", Busy, 1'b1);
            if (i == 0) begin
                ReqA = 1; AddrA = 2'd3; FunSelA = FS_INC; DataA = 16'h0ABC;
                push_op(1'b0, 1'b0, 2'd3, FS_INC, 16'h0ABC);
            end
            if (i == 3) begin ReqB = 0; ClrB = 0; end
        end
        @(negedge Clock);
        chk("t4_idle_gap", {GntA, Busy, RegE}, '0);
        @(negedge Clock);
        chk("t4_gnta_after_clear", GntA, 1'b1);
        ReqA = 0;
        @(negedge Clock);

        // Asynchronous reset in the second clear cycle aborts without a grant.
        ReqB = 1; ClrB = 1;
        @(negedge Clock);
        chk("t6_first_clear", RegE, 4'b0001);
        @(posedge Clock);
        #2;
        ResetN = 0;
        ReqB = 0; ClrB = 0;
        #1;
        chk("t6_async_reset", {GntA, GntB, ErrA, ErrB, Busy, RegE, RegFunSel, RegI}, '0);
        @(negedge Clock);
        ResetN = 1;
        @(negedge Clock);
        chk("t6_after_release", {GntB, Busy}, 2'b00);
        ReqA = 1; AddrA = 2'd1; FunSelA = FS_LOAD; DataA = 16'h7777;
        push_op(1'b0, 1'b0, 2'd1, FS_LOAD, 16'h7777);
        @(negedge Clock);
        chk("t6_gnta", GntA, 1'b1);
        ReqA = 0;
        @(negedge Clock);

        // Three-register bank: address 3 is out of range.
        c_ReqA = 1; c_AddrA = 2'd3; c_FunSelA = FS_LOAD; c_DataA = 16'h1234;
        @(negedge Clock);
        chk("t5_oob", {c_GntA, c_ErrA, c_RegE}, {1'b1, 1'b1, 3'b000});
        c_AddrA = 2'd2;
        @(negedge Clock);
        chk("t5_idle", {c_GntA, c_Busy}, 2'b00);
        @(negedge Clock);
        chk("t5_inrange", {c_GntA, c_ErrA, c_RegE}, {1'b1, 1'b0, 3'b100});
        c_ReqA = 0;
        @(negedge Clock);

        chk("final_sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
